// File: rtl/pipeline_types.sv
// Shared LC-3b pipeline types: datapath word, opcode encoding, the EX/MEM
// storage bundle and the memory-access stage state encoding.
package pipeline_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [3:0] {
        OP_BR   = 4'h0,
        OP_ADD  = 4'h1,
        OP_LDB  = 4'h2,
        OP_STB  = 4'h3,
        OP_JSR  = 4'h4,
        OP_AND  = 4'h5,
        OP_LDR  = 4'h6,
        OP_STR  = 4'h7,
        OP_RTI  = 4'h8,
        OP_NOT  = 4'h9,
        OP_LDI  = 4'hA,
        OP_STI  = 4'hB,
        OP_JMP  = 4'hC,
        OP_SHF  = 4'hD,
        OP_LEA  = 4'hE,
        OP_TRAP = 4'hF
    } lc3b_opcode;

    typedef struct packed {
        logic       valid;
        lc3b_opcode opcode;
        lc3b_word   addr;
        lc3b_word   store_data;
        lc3b_word   alu_out;
    } storage_t;

    typedef enum logic {
        S_FIRST    = 1'b0,
        S_INDIRECT = 1'b1
    } mem_state_t;

    function automatic logic isMemOp(input lc3b_opcode op);
        return (op == OP_LDR) || (op == OP_LDB) || (op == OP_LDI) ||
               (op == OP_STR) || (op == OP_STB) || (op == OP_STI);
    endfunction

    function automatic logic isIndirectOp(input lc3b_opcode op);
        return (op == OP_LDI) || (op == OP_STI);
    endfunction

endpackage

// File: rtl/mem_byte_align.sv
// Byte-lane steering for stores and byte selection with sign extension for
// LDB loads. Purely combinational; the caller decides when the outputs apply.
module mem_byte_align
    import pipeline_types::*;
(
    input  lc3b_opcode  opcode_i,
    input  logic        addrLsb_i,
    input  lc3b_word    storeData_i,
    input  lc3b_word    readData_i,
    output logic [1:0]  byteEnable_o,
    output lc3b_word    writeData_o,
    output lc3b_word    loadByte_o
);

    logic [7:0] selByte;

    always_comb begin
        byteEnable_o = 2'b11;
        writeData_o  = storeData_i;
        // STB replicates the low byte so either lane carries the right value.
        if (opcode_i == OP_STB) begin
            byteEnable_o = addrLsb_i ? 2'b10 : 2'b01;
            writeData_o  = {storeData_i[7:0], storeData_i[7:0]};
        end
    end

    always_comb begin
        selByte    = addrLsb_i ? readData_i[15:8] : readData_i[7:0];
        loadByte_o = {{8{selByte[7]}}, selByte};
    end

endmodule

// File: rtl/mem_access_stage.sv
// LC-3b memory-access stage: issues word, byte and two-phase indirect data
// accesses, stalls upstream while waiting, and hands results to MEM/WB.
module mem_access_stage
    import pipeline_types::*;
(
    input  logic        clk,
    input  logic        reset,
    input  storage_t    stage_in,
    output lc3b_word    dmem_address,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [1:0]  dmem_byte_enable,
    output lc3b_word    dmem_wdata,
    input  lc3b_word    dmem_rdata,
    input  logic        dmem_resp,
    output logic        stall,
    output logic        wb_valid,
    output lc3b_word    wb_data
);

    mem_state_t state_q, state_d;
    lc3b_word   ptr_q, ptr_d;

    logic       memOp;
    logic       indirectOp;
    logic       reqRead;
    logic       reqWrite;
    lc3b_word   reqAddr;
    logic       memBusy;
    logic       complete;
    logic       passThrough;
    logic [1:0] alignBe;
    lc3b_word   alignWd;
    lc3b_word   loadByte;
    lc3b_word   resultData;

    mem_byte_align u_align (
        .opcode_i     (stage_in.opcode),
        .addrLsb_i    (stage_in.addr[0]),
        .storeData_i  (stage_in.store_data),
        .readData_i   (dmem_rdata),
        .byteEnable_o (alignBe),
        .writeData_o  (alignWd),
        .loadByte_o   (loadByte)
    );

    always_comb begin
        memOp      = stage_in.valid && isMemOp(stage_in.opcode);
        indirectOp = stage_in.valid && isIndirectOp(stage_in.opcode);
    end

    // Requests come only from state, stage_in and ptr; dmem_resp merely
    // decides completion and the next state.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        reqRead     = 1'b0;
        reqWrite    = 1'b0;
        reqAddr     = '0;
        memBusy     = 1'b0;
        complete    = 1'b0;
        passThrough = 1'b0;
        case (state_q)
            S_FIRST: begin
                if (memOp) begin
                    memBusy  = 1'b1;
                    reqAddr  = (stage_in.opcode == OP_LDB || stage_in.opcode == OP_STB)
                               ? stage_in.addr : {stage_in.addr[15:1], 1'b0};
                    reqWrite = (stage_in.opcode == OP_STR) || (stage_in.opcode == OP_STB);
                    reqRead  = !reqWrite;
                    if (dmem_resp) begin
                        if (indirectOp) begin
                            state_d = S_INDIRECT;
                            ptr_d   = dmem_rdata;
                        end else begin
                            complete = 1'b1;
                        end
                    end
                end else if (stage_in.valid) begin
                    passThrough = 1'b1;
                end
            end
            S_INDIRECT: begin
                if (indirectOp) begin
                    memBusy  = 1'b1;
                    reqAddr  = {ptr_q[15:1], 1'b0};
                    reqRead  = (stage_in.opcode == OP_LDI);
                    reqWrite = (stage_in.opcode == OP_STI);
                    if (dmem_resp) begin
                        complete = 1'b1;
                        state_d  = S_FIRST;
                    end
                end else begin
                    state_d = S_FIRST;
                end
            end
            default: state_d = S_FIRST;
        endcase
    end

    always_comb begin
        resultData = stage_in.alu_out;
        if (complete) begin
            case (stage_in.opcode)
                OP_LDR, OP_LDI: resultData = dmem_rdata;
                OP_LDB:         resultData = loadByte;
                default:        resultData = stage_in.alu_out;
            endcase
        end
    end

    // Reset forces every output low immediately, aborting any access.
    always_comb begin
        dmem_address     = '0;
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_byte_enable = 2'b00;
        dmem_wdata       = '0;
        stall            = 1'b0;
        wb_valid         = 1'b0;
        wb_data          = '0;
        if (!reset) begin
            dmem_address     = reqAddr;
            dmem_read        = reqRead;
            dmem_write       = reqWrite;
            dmem_byte_enable = reqWrite ? alignBe : (reqRead ? 2'b11 : 2'b00);
            dmem_wdata       = reqWrite ? alignWd : '0;
            stall            = memBusy && !complete;
            wb_valid         = complete || passThrough;
            wb_data          = (complete || passThrough) ? resultData : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FIRST;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: drives ops with a scripted memory
// responder and scores write-back results through an expected-value queue.
module tb_mem_access_stage;
    import pipeline_types::*;

    logic       clk;
    logic       reset;
    storage_t   stage_in;
    lc3b_word   dmem_address;
    logic       dmem_read;
    logic       dmem_write;
    logic [1:0] dmem_byte_enable;
    lc3b_word   dmem_wdata;
    lc3b_word   dmem_rdata;
    logic       dmem_resp;
    logic       stall;
    logic       wb_valid;
    lc3b_word   wb_data;

    int checks = 0;
    int errors = 0;
    lc3b_word sbQ[$];

    mem_access_stage dut (
        .clk              (clk),
        .reset            (reset),
        .stage_in         (stage_in),
        .dmem_address     (dmem_address),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_byte_enable (dmem_byte_enable),
        .dmem_wdata       (dmem_wdata),
        .dmem_rdata       (dmem_rdata),
        .dmem_resp        (dmem_resp),
        .stall            (stall),
        .wb_valid         (wb_valid),
        .wb_data          (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One op: memory answers lat1 cycles after issue, and for indirect ops the
    // second phase answers lat2 cycles after it starts.
    task automatic applyStimulus(input lc3b_opcode op, input lc3b_word addr, input lc3b_word sd,
                                 input lc3b_word alu, input int lat1, input lc3b_word rd1,
                                 input int lat2, input lc3b_word rd2, input lc3b_word expA1,
                                 input lc3b_word expA2, input logic [1:0] expBe,
                                 input lc3b_word expWd, input lc3b_word expWb);
        bit isMem, isInd, phase2, expRd, expWr;
        int total;
        isMem = op inside {OP_LDR, OP_LDB, OP_LDI, OP_STR, OP_STB, OP_STI};
        isInd = op inside {OP_LDI, OP_STI};
        total = !isMem ? 0 : (isInd ? lat1 + 1 + lat2 : lat1);
        sbQ.push_back(expWb);
        @(posedge clk); #2;
        stage_in = '{valid: 1'b1, opcode: op, addr: addr, store_data: sd, alu_out: alu};
        for (int c = 0; c <= total; c++) begin
            if (c > 0) begin
                @(posedge clk); #2;
            end
            dmem_resp  = isMem && (c == lat1 || c == total);
            dmem_rdata = (c <= lat1) ? rd1 : rd2;
            @(negedge clk);
            phase2 = isInd && (c > lat1);
            expRd  = isMem && (phase2 ? (op == OP_LDI) : (op inside {OP_LDR, OP_LDB, OP_LDI, OP_STI}));
            expWr  = isMem && (phase2 ? (op == OP_STI) : (op inside {OP_STR, OP_STB}));
            checkOutput("stall", 16'(stall), 16'(isMem && c != total));
            checkOutput("dmem_read", 16'(dmem_read), 16'(expRd));
            checkOutput("dmem_write", 16'(dmem_write), 16'(expWr));
            if (isMem) checkOutput("dmem_address", dmem_address, phase2 ? expA2 : expA1);
            if (expWr) begin
                checkOutput("dmem_byte_enable", 16'(dmem_byte_enable), 16'(expBe));
                checkOutput("dmem_wdata", dmem_wdata, expWd);
            end
            checkOutput("wb_valid", 16'(wb_valid), 16'(c == total));
            if (wb_valid) begin
                if (sbQ.size() == 0) checkOutput("sb_pending", 16'(sbQ.size()), 16'd1);
                else checkOutput("wb_data", wb_data, sbQ.pop_front());
            end
        end
    endtask

    task automatic applyIdle(input logic spuriousResp);
        @(posedge clk); #2;
        stage_in   = '0;
        dmem_resp  = spuriousResp;
        dmem_rdata = 16'hDEAD;
        @(negedge clk);
        checkOutput("idle_stall", 16'(stall), 16'd0);
        checkOutput("idle_wb_valid", 16'(wb_valid), 16'd0);
        checkOutput("idle_req", 16'({dmem_read, dmem_write}), 16'd0);
    endtask

    initial begin
        reset      = 1'b1;
        dmem_resp  = 1'b0;
        dmem_rdata = '0;
        stage_in   = '{valid: 1'b1, opcode: OP_LDR, addr: 16'h3001, store_data: 16'h0, alu_out: 16'h0};
        #13;
        checkOutput("rst_read", 16'(dmem_read), 16'd0);
        checkOutput("rst_address", dmem_address, 16'h0000);
        checkOutput("rst_stall", 16'(stall), 16'd0);
        checkOutput("rst_wb_valid", 16'(wb_valid), 16'd0);
        @(posedge clk); #2;
        reset    = 1'b0;
        stage_in = '0;

        // LDR x3001 -> x3000, three-cycle wait then x1234.
        applyStimulus(OP_LDR, 16'h3001, 16'h0, 16'h0, 3, 16'h1234, 0, 16'h0,
                      16'h3000, 16'h0, 2'b11, 16'h0, 16'h1234);
        applyStimulus(OP_LDB, 16'h4001, 16'h0, 16'h0, 1, 16'h80FF, 0, 16'h0,
                      16'h4001, 16'h0, 2'b11, 16'h0, 16'hFF80);
        applyStimulus(OP_LDB, 16'h4000, 16'h0, 16'h0, 0, 16'h80FF, 0, 16'h0,
                      16'h4000, 16'h0, 2'b11, 16'h0, 16'hFFFF);
        applyStimulus(OP_STB, 16'h4000, 16'hAB12, 16'h5555, 2, 16'h0, 0, 16'h0,
                      16'h4000, 16'h0, 2'b01, 16'h1212, 16'h5555);
        applyStimulus(OP_STB, 16'h4001, 16'h00C7, 16'h6666, 1, 16'h0, 0, 16'h0,
                      16'h4001, 16'h0, 2'b10, 16'hC7C7, 16'h6666);
        applyStimulus(OP_STR, 16'h5007, 16'hBEEF, 16'h7777, 0, 16'h0, 0, 16'h0,
                      16'h5006, 16'h0, 2'b11, 16'hBEEF, 16'h7777);
        applyStimulus(OP_STI, 16'h2000, 16'hC0DE, 16'h8888, 1, 16'h5003, 2, 16'h0,
                      16'h2000, 16'h5002, 2'b11, 16'hC0DE, 16'h8888);
        applyStimulus(OP_LDI, 16'h2101, 16'h0, 16'h0, 0, 16'h0A11, 1, 16'h4321,
                      16'h2100, 16'h0A10, 2'b11, 16'h0, 16'h4321);
        applyStimulus(OP_ADD, 16'h0, 16'h0, 16'h0042, 0, 16'h0, 0, 16'h0,
                      16'h0, 16'h0, 2'b11, 16'h0, 16'h0042);
        applyStimulus(OP_LDR, 16'h1110, 16'h0, 16'h0, 1, 16'h0101, 0, 16'h0,
                      16'h1110, 16'h0, 2'b11, 16'h0, 16'h0101);
        applyIdle(1'b1);

        // LDI interrupted by reset while in the indirect phase.
        @(posedge clk); #2;
        stage_in   = '{valid: 1'b1, opcode: OP_LDI, addr: 16'h6000, store_data: 16'h0, alu_out: 16'h0};
        dmem_resp  = 1'b1;
        dmem_rdata = 16'h7001;
        @(negedge clk);
        checkOutput("ldi_ph1_stall", 16'(stall), 16'd1);
        @(posedge clk); #2;
        dmem_resp = 1'b0;
        @(negedge clk);
        checkOutput("ldi_ph2_address", dmem_address, 16'h7000);
        checkOutput("ldi_ph2_read", 16'(dmem_read), 16'd1);
        #1 reset = 1'b1;
        #1;
        checkOutput("abort_read", 16'(dmem_read), 16'd0);
        checkOutput("abort_address", dmem_address, 16'h0000);
        checkOutput("abort_stall", 16'(stall), 16'd0);
        checkOutput("abort_wb_valid", 16'(wb_valid), 16'd0);
        @(posedge clk); #2;
        stage_in = '0;
        reset    = 1'b0;
        applyStimulus(OP_LDR, 16'h3004, 16'h0, 16'h0, 1, 16'h9ABC, 0, 16'h0,
                      16'h3004, 16'h0, 2'b11, 16'h0, 16'h9ABC);
        applyIdle(1'b0);

        checkOutput("sb_drained", 16'(sbQ.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
